subcarrier_mapper: RTL

SUBCARRIER_MAPPER -- requirements
Module: subcarrier_mapper

---
 rtl/subcarrier_mapper_pkg.sv | 23 ++
 rtl/subcarrier_mapper_subc_classifier.sv | 42 ++++
 rtl/subcarrier_mapper.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/subcarrier_mapper_pkg.sv
// Shared types for the OFDM transmit chain: subcarrier class encoding and
// the mapper FSM state, also consumed by the scrambler and IFFT stages.
`timescale 1ns/1ps
package subcarrier_mapper_pkg;

    typedef enum logic [1:0] {
        SC_NULL  = 2'd0,
        SC_DATA  = 2'd1,
        SC_PILOT = 2'd2,
        SC_DC    = 2'd3
    } subc_class_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mapper_state_e;

    // A pilot_step of 1 still needs a one-bit counter to keep the port legal.
    function automatic int pilot_cnt_width(input int step);
        return (step > 1) ? $clog2(step) : 1;
    endfunction

endpackage

// File: rtl/subcarrier_mapper_subc_classifier.sv
// Classifies subcarrier k as null guard, DC, pilot or data; purely combinational.
`timescale 1ns/1ps
module subc_classifier
    import subcarrier_mapper_pkg::*;
#(
    parameter int fft_size_log2 = 10,
    parameter int guard_lo      = 100,
    parameter int guard_hi      = 99,
    parameter int pilot_step    = 8,
    parameter int pc_w          = pilot_cnt_width(pilot_step)
) (
    input  logic [fft_size_log2-1:0] k,
    input  logic [pc_w-1:0]          pilot_cnt,
    output subc_class_e              subc_class
);

    localparam int N  = 1 << fft_size_log2;
    localparam int KX = fft_size_log2 + 1;

    // One extra bit so guard bounds of 0 or N compare without wrapping.
    localparam logic [KX-1:0] LO_END   = KX'(guard_lo);
    localparam logic [KX-1:0] HI_START = KX'(N - guard_hi);
    localparam logic [fft_size_log2-1:0] K_DC = fft_size_log2'(N / 2);

    logic [KX-1:0] k_x;
    logic          in_guard;

    assign k_x      = {1'b0, k};
    assign in_guard = (k_x < LO_END) || (k_x >= HI_START);

    always_comb begin
        subc_class = SC_DATA;
        if (in_guard) begin
            subc_class = SC_NULL;
        end else if (k == K_DC) begin
            subc_class = SC_DC;
        end else if (pilot_cnt == '0) begin
            subc_class = SC_PILOT;
        end
    end

endmodule

// File: rtl/subcarrier_mapper.sv
// OFDM subcarrier mapper: walks k = 0..N-1 per frame, inserting guards, DC
// and pilots, and pulls data symbols with a ready/valid stall on data slots.
`timescale 1ns/1ps
module subcarrier_mapper
    import subcarrier_mapper_pkg::*;
#(
    parameter int fft_depth     = 12,
    parameter int fft_size_log2 = 10,
    parameter int guard_lo      = 100,
    parameter int guard_hi      = 99,
    parameter int pilot_step    = 8,
    parameter int pilot_amp     = 724
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        istart,
    input  logic [2:0]                  index_M_in,
    input  logic [3:0]                  index_SS_in,
    input  logic signed [fft_depth-1:0] idata_i,
    input  logic signed [fft_depth-1:0] idata_q,
    input  logic                        idata_val,
    output logic                        odata_rdy,
    output logic signed [fft_depth-1:0] osubc_i,
    output logic signed [fft_depth-1:0] osubc_q,
    output logic [1:0]                  oindex_subc,
    output logic [2:0]                  index_M_out,
    output logic [3:0]                  index_SS_out,
    output logic                        osop,
    output logic                        oval,
    output logic                        oeop,
    output logic                        obusy
);

    localparam int KW   = fft_size_log2;
    localparam int PC_W = pilot_cnt_width(pilot_step);

    localparam logic [KW-1:0]   K_FIRST = '0;
    localparam logic [KW-1:0]   K_LAST  = '1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(pilot_step - 1);
    localparam logic signed [fft_depth-1:0] PILOT_I = fft_depth'(pilot_amp);

    mapper_state_e         state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [2:0]            m_q, m_d;
    logic [3:0]            ss_q, ss_d;
    logic                  oval_q, oval_d;
    logic                  osop_q, osop_d;
    logic                  oeop_q, oeop_d;
    logic signed [fft_depth-1:0] oi_q, oi_d;
    logic signed [fft_depth-1:0] oq_q, oq_d;
    subc_class_e           cls_q, cls_d;

    subc_class_e subc_class;
    logic        advance;

    subc_classifier #(
        .fft_size_log2 (fft_size_log2),
        .guard_lo      (guard_lo),
        .guard_hi      (guard_hi),
        .pilot_step    (pilot_step),
        .pc_w          (PC_W)
    ) u_classifier (
        .k          (k_q),
        .pilot_cnt  (pc_q),
        .subc_class (subc_class)
    );

    // Only data slots wait on the source; every other slot always advances.
    assign odata_rdy = (state_q == ST_RUN) && (subc_class == SC_DATA);
    assign advance   = (state_q == ST_RUN) && ((subc_class != SC_DATA) || idata_val);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pc_d    = pc_q;
        m_d     = m_q;
        ss_d    = ss_q;
        oval_d  = 1'b0;
        osop_d  = 1'b0;
        oeop_d  = 1'b0;
        oi_d    = '0;
        oq_d    = '0;
        cls_d   = SC_NULL;
        case (state_q)
            ST_IDLE: begin
                if (istart) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    pc_d    = '0;
                    m_d     = index_M_in;
                    ss_d    = index_SS_in;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    oval_d = 1'b1;
                    cls_d  = subc_class;
                    osop_d = (k_q == K_FIRST);
                    oeop_d = (k_q == K_LAST);
                    case (subc_class)
                        SC_PILOT: oi_d = PILOT_I;
                        SC_DATA: begin
                            oi_d = idata_i;
                            oq_d = idata_q;
                        end
                        default: ;
                    endcase
                    // Pilot spacing counts active non-DC slots only.
                    if (subc_class == SC_PILOT || subc_class == SC_DATA) begin
                        pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PC_W'(1);
                    end
                    if (k_q == K_LAST) begin
                        state_d = ST_IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            pc_q    <= '0;
            m_q     <= '0;
            ss_q    <= '0;
            oval_q  <= 1'b0;
            osop_q  <= 1'b0;
            oeop_q  <= 1'b0;
            oi_q    <= '0;
            oq_q    <= '0;
            cls_q   <= SC_NULL;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pc_q    <= pc_d;
            m_q     <= m_d;
            ss_q    <= ss_d;
            oval_q  <= oval_d;
            osop_q  <= osop_d;
            oeop_q  <= oeop_d;
            oi_q    <= oi_d;
            oq_q    <= oq_d;
            cls_q   <= cls_d;
        end
    end

    assign osubc_i      = oi_q;
    assign osubc_q      = oq_q;
    assign oindex_subc  = cls_q;
    assign index_M_out  = m_q;
    assign index_SS_out = ss_q;
    assign osop         = osop_q;
    assign oval         = oval_q;
    assign oeop         = oeop_q;
    assign obusy        = (state_q == ST_RUN);

endmodule
